// File: rtl/fnd_decoder.sv
// fnd_decoder: readback monitor for the six-digit multiplexed 7-seg bus.
// Rebuilds the scanned image, filters it for stability, parses it to a value.
// Ports:
//   fnd_clk, rst      : clock, asynchronous active-high reset
//   fnd_s, fnd_d      : one-cold digit select, segments (bit0=a..bit6=g, bit7=dp)
//   value, numeric    : decoded two's complement value and its validity
//   blank, image      : all-blank flag, accepted frame {pos5..pos0}
//   frame_valid, busy : one-cycle update pulse, decode in progress
module fnd_decoder #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic        fnd_clk,
    input  logic        rst,
    input  logic [5:0]  fnd_s,
    input  logic [7:0]  fnd_d,
    output logic [31:0] value,
    output logic        numeric,
    output logic        blank,
    output logic [47:0] image,
    output logic        frame_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_FRAMES);

    logic [5:0][7:0] cap_q, cap_d;
    logic [5:0][7:0] cand_q, cand_d;
    logic [5:0][7:0] work_q, work_d;
    logic [5:0]      seen_q, seen_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pub_q, pub_d;
    state_t          state_q, state_d;
    logic [2:0]      pos_q, pos_d;
    logic [19:0]     acc_q, acc_d;
    logic            neg_q, neg_d;
    logic            ok_q, ok_d;
    logic            sd_q, sd_d;
    logic [31:0]     value_q, value_d;
    logic            numeric_q, numeric_d;
    logic            blank_q, blank_d;
    logic [47:0]     image_q, image_d;
    logic            fv_q, fv_d;
    logic            busy_q, busy_d;

    logic [5:0]  sel;
    logic        sel_ok;
    logic        frame_done;
    logic        accept;
    logic [7:0]  glyph;
    logic        is_digit;
    logic [3:0]  digit;
    logic [31:0] mag;

    // Exactly one select line low; anything else breaks the frame.
    assign sel        = ~fnd_s;
    assign sel_ok     = (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    assign frame_done = (seen_q == 6'h3F);
    assign mag        = {12'd0, acc_q};

    always_comb begin
        cap_d  = cap_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        seen_d = frame_done ? 6'd0 : seen_q;
        if (sel_ok) begin
            for (int k = 0; k < 6; k++) begin
                if (sel[k]) cap_d[k] = fnd_d;
            end
            seen_d = seen_d | sel;
        end else begin
            seen_d = 6'd0;
        end
        if (frame_done) begin
            cand_d = cap_q;
            if (cap_q != cand_q) cnt_d = 4'd1;
            else if (cnt_q < STABLE) cnt_d = cnt_q + 4'd1;
        end
    end

    // Only a frame that differs from what is already published is decoded.
    assign accept = frame_done && (cnt_d == STABLE) && (state_q == IDLE)
                    && (!pub_q || (cap_q != image_q));

    // Glyph classification; dp is ignored.
    always_comb begin
        glyph    = work_q[pos_q];
        is_digit = 1'b1;
        digit    = 4'd0;
        unique case (glyph[6:0])
            7'h3F:   digit = 4'd0;
            7'h06:   digit = 4'd1;
            7'h5B:   digit = 4'd2;
            7'h4F:   digit = 4'd3;
            7'h66:   digit = 4'd4;
            7'h6D:   digit = 4'd5;
            7'h7D:   digit = 4'd6;
            7'h07:   digit = 4'd7;
            7'h7F:   digit = 4'd8;
            7'h67:   digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        pos_d     = pos_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        ok_d      = ok_q;
        sd_d      = sd_q;
        value_d   = value_q;
        numeric_d = numeric_q;
        blank_d   = blank_q;
        image_d   = image_q;
        pub_d     = pub_q;
        fv_d      = 1'b0;
        busy_d    = accept || (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = cap_q;
                    pos_d   = 3'd5;
                    acc_d   = 20'd0;
                    neg_d   = 1'b0;
                    ok_d    = 1'b1;
                    sd_d    = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (glyph[6:0] == 7'h40) begin
                    if (pos_q == 3'd5) neg_d = 1'b1;
                    else ok_d = 1'b0;
                end else if (glyph[6:0] == 7'h00) begin
                    // Leading blanks skip; a gap after a digit is not a number.
                    if (sd_q) ok_d = 1'b0;
                end else if (is_digit) begin
                    acc_d = acc_q * 20'd10 + {16'd0, digit};
                    sd_d  = 1'b1;
                end else begin
                    ok_d = 1'b0;
                end
                if (pos_q == 3'd0) state_d = DONE;
                else pos_d = pos_q - 3'd1;
            end
            DONE: begin
                numeric_d = ok_q && sd_q;
                if (!numeric_d) value_d = 32'd0;
                else if (neg_q) value_d = 32'd0 - mag;
                else value_d = mag;
                blank_d = (work_q == 48'd0);
                image_d = work_q;
                pub_d   = 1'b1;
                fv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fnd_clk or posedge rst) begin
        if (rst) begin
            cap_q     <= '0;
            cand_q    <= '0;
            work_q    <= '0;
            seen_q    <= 6'd0;
            cnt_q     <= 4'd0;
            pub_q     <= 1'b0;
            state_q   <= IDLE;
            pos_q     <= 3'd0;
            acc_q     <= 20'd0;
            neg_q     <= 1'b0;
            ok_q      <= 1'b0;
            sd_q      <= 1'b0;
            value_q   <= 32'd0;
            numeric_q <= 1'b0;
            blank_q   <= 1'b0;
            image_q   <= 48'd0;
            fv_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cap_q     <= cap_d;
            cand_q    <= cand_d;
            work_q    <= work_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
            pub_q     <= pub_d;
            state_q   <= state_d;
            pos_q     <= pos_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            ok_q      <= ok_d;
            sd_q      <= sd_d;
            value_q   <= value_d;
            numeric_q <= numeric_d;
            blank_q   <= blank_d;
            image_q   <= image_d;
            fv_q      <= fv_d;
            busy_q    <= busy_d;
        end
    end

    assign value       = value_q;
    assign numeric     = numeric_q;
    assign blank       = blank_q;
    assign image       = image_q;
    assign frame_valid = fv_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fnd_decoder.sv
// tb_fnd_decoder: directed bench for fnd_decoder.
// Expected frames are queued at stimulus time and popped on frame_valid.
module tb_fnd_decoder;

    logic        fnd_clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  fnd_s = 6'h3F;
    logic [7:0]  fnd_d = 8'h00;
    logic [31:0] value;
    logic        numeric;
    logic        blank;
    logic [47:0] image;
    logic        frame_valid;
    logic        busy;

    fnd_decoder #(
        .STABLE_FRAMES(2)
    ) dut (
        .fnd_clk     (fnd_clk),
        .rst         (rst),
        .fnd_s       (fnd_s),
        .fnd_d       (fnd_d),
        .value       (value),
        .numeric     (numeric),
        .blank       (blank),
        .image       (image),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    always #5 fnd_clk = ~fnd_clk;

    typedef struct {
        logic [31:0] value;
        logic        numeric;
        logic        blank;
        logic [47:0] image;
    } exp_t;

    localparam logic [47:0] F_BLANK = 48'h000000000000;
    localparam logic [47:0] F_123456 = 48'h065B4F666D7D;
    localparam logic [47:0] F_NEG12 = 48'h40000000065B;
    localparam logic [47:0] F_DASH = 48'h404040404040;
    localparam logic [47:0] F_ERROR = 48'h007950505C50;
    localparam logic [47:0] F_ONE = 48'h3F3F3F3F3F06;
    localparam logic [47:0] F_TWO = 48'h3F3F3F3F3F5B;
    localparam logic [47:0] F_654321 = 48'h7D6D664F5B06;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail = 0;
    int   pulses = 0;
    int   pulse_cyc = 0;
    int   cyc = 0;
    logic prev_fv = 1'b0;

    always @(posedge fnd_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] req);
        n_asserts++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
        end
    endtask

    task automatic expect_frame(input logic [47:0] img, input logic [31:0] v,
                                input logic num, input logic blk);
        exp_t e;
        e.value   = v;
        e.numeric = num;
        e.blank   = blk;
        e.image   = img;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge fnd_clk);
            fnd_s = 6'h3F;
            fnd_d = 8'h00;
        end
    endtask

    task automatic put(input logic [47:0] img, input int k);
        logic [5:0] one;
        one = 6'b000001;
        @(negedge fnd_clk);
        fnd_s = ~(one << k);
        fnd_d = img[k*8 +: 8];
    endtask

    task automatic scan(input logic [47:0] img, input int nframes);
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < 6; k++) put(img, k);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge fnd_clk);
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge fnd_clk) begin
        exp_t e;
        if (frame_valid === 1'b1) begin
            pulses++;
            pulse_cyc = cyc;
            check("fv_single_cycle", 64'(prev_fv), 64'd0);
            check("pulse_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("value", 64'(value), 64'(e.value));
                check("numeric", 64'(numeric), 64'(e.numeric));
                check("blank", 64'(blank), 64'(e.blank));
                check("image", 64'(image), 64'(e.image));
            end
        end
        prev_fv = frame_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int e_edge;

        rst = 1'b1;
        repeat (3) @(negedge fnd_clk);
        check("rst_value", 64'(value), 64'd0);
        check("rst_numeric", 64'(numeric), 64'd0);
        check("rst_blank", 64'(blank), 64'd0);
        check("rst_image", 64'(image), 64'd0);
        check("rst_fv", 64'(frame_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        idle(2);
        expect_frame(F_BLANK, 32'd0, 1'b0, 1'b1);
        scan(F_BLANK, 2);
        drain("drain_blank");
        p0 = pulses;
        scan(F_BLANK, 10);
        idle(12);
        check("blank_repeat_pulses", 64'(pulses - p0), 64'd0);

        idle(2);
        expect_frame(F_123456, 32'h0001E240, 1'b1, 1'b0);
        scan(F_123456, 2);
        drain("drain_123456");

        idle(2);
        expect_frame(F_NEG12, 32'hFFFFFFF4, 1'b1, 1'b0);
        scan(F_NEG12, 2);
        drain("drain_neg12");

        idle(2);
        expect_frame(F_DASH, 32'd0, 1'b0, 1'b0);
        scan(F_DASH, 2);
        drain("drain_dash");

        idle(2);
        expect_frame(F_ERROR, 32'd0, 1'b0, 1'b0);
        scan(F_ERROR, 2);
        drain("drain_error");

        idle(2);
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            scan(F_ONE, 1);
            scan(F_TWO, 1);
        end
        idle(12);
        check("alternate_no_pulse", 64'(pulses - p0), 64'd0);

        idle(2);
        p0 = pulses;
        scan(F_ONE, 1);
        for (int k = 0; k < 3; k++) put(F_ONE, k);
        @(negedge fnd_clk);
        fnd_s = 6'b111100;
        fnd_d = 8'h06;
        for (int k = 3; k < 6; k++) put(F_ONE, k);
        idle(12);
        check("illegal_discard", 64'(pulses - p0), 64'd0);
        expect_frame(F_ONE, 32'd1, 1'b1, 1'b0);
        scan(F_ONE, 1);
        drain("drain_slip");

        idle(2);
        p0 = pulses;
        scan(F_654321, 2);
        repeat (5) @(posedge fnd_clk);
        #1;
        check("busy_mid_decode", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_value", 64'(value), 64'd0);
        check("mid_rst_numeric", 64'(numeric), 64'd0);
        check("mid_rst_blank", 64'(blank), 64'd0);
        check("mid_rst_image", 64'(image), 64'd0);
        check("mid_rst_fv", 64'(frame_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge fnd_clk);
        rst = 1'b0;
        idle(12);
        check("mid_rst_no_pulse", 64'(pulses - p0), 64'd0);

        expect_frame(F_654321, 32'h0009FBF1, 1'b1, 1'b0);
        scan(F_654321, 2);
        e_edge = cyc + 1;
        @(negedge fnd_clk);
        check("busy_at_E", 64'(busy), 64'd0);
        @(negedge fnd_clk);
        check("busy_at_E1", 64'(busy), 64'd1);
        repeat (6) @(negedge fnd_clk);
        check("fv_at_E7", 64'(frame_valid), 64'd0);
        @(negedge fnd_clk);
        check("fv_at_E8", 64'(frame_valid), 64'd1);
        check("busy_at_E8", 64'(busy), 64'd1);
        @(negedge fnd_clk);
        check("busy_at_E9", 64'(busy), 64'd0);
        check("pulse_edge", 64'(pulse_cyc), 64'(e_edge + 8));
        drain("drain_latency");

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_decoder.md
# fnd_decoder

Scan-side decoder for the six-digit multiplexed seven-segment bus. It samples the active-low digit select (`fnd_s`) and segment anode (`fnd_d`) lines each clock, rebuilds the six-glyph display image, and filters it for stability. It then converts the image back into a signed 32-bit value plus status flags. It sits beside the display path as a readback/self-check monitor, so the calculator core and the testbench can confirm what the display actually shows.

## Interface
- `STABLE_FRAMES`, default 2: number of consecutive identical complete frames required before a frame is accepted (legal range 1–15).
- `fnd_clk`  in  1  — single clock; the same clock that drives the scanned display bus.
- `rst`  in  1  — asynchronous, active-high reset.
- `fnd_s`  in  6  — digit select, one-cold; bit k low means digit position k is being driven.
- `fnd_d`  in  8  — segment pattern for the selected position; bit0 = a … bit6 = g, bit7 = dp.
- `value`  out  32  — decoded signed value, two's complement.
- `numeric`  out  1  — `value` is meaningful (the frame parsed as a number).
- `blank`  out  1  — the accepted frame was all blank (every glyph 0x00).
- `image`  out  48  — the accepted frame as {pos5, …, pos0}, 8 bits per position.
- `frame_valid`  out  1  — one-cycle pulse when `value`, `numeric`, `blank` and `image` update.
- `busy`  out  1  — high while the decode FSM is in DECODE or DONE.

## Operation
- **Capture**
  - Each cycle in which `fnd_s` has exactly one zero bit at position k: `cap[k] <= fnd_d` and `seen[k] <= 1`.
  - A repeated position overwrites the earlier capture (latest wins).
- **Illegal select**
  - Any cycle in which `fnd_s` has zero or ≥2 zero bits clears `seen` and drops the partial frame.
- **Frame complete**
  - When `seen == 6'h3F`, `cap` is latched as the candidate and `seen` is cleared.
  - The candidate is compared with the previous candidate. Equal → stability counter +1, saturating at `STABLE_FRAMES`. Unequal → counter = 1.
- **Accept**
  - Condition: counter reaches `STABLE_FRAMES` and the FSM is IDLE, and either no frame has been published since reset or the candidate differs from `image`.
  - On accept, the candidate is copied into the work register and the FSM goes to DECODE.
  - A stable frame that arrives while `busy` is high is not accepted. It is re-evaluated on the next frame completion after IDLE.
- **Glyph map**
  - Digits: 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x67=9.
  - 0x00 = blank, 0x40 = minus.
  - Bit7 (dp) is ignored for classification.
  - Any other pattern is non-digit.
- **FSM**
  - IDLE → DECODE: on accept.
  - DECODE: 6 cycles, positions 5 down to 0, one per cycle.
    - Position 5 minus sets `neg`. Minus at any other position clears numeric.
    - Leading blanks are skipped.
    - A digit d gives `acc <= acc*10 + d` and sets `seen_digit`.
    - A blank after the first digit, or any non-digit glyph, clears numeric.
    - `acc` is 20 bits; the maximum is 999999.
  - DECODE → DONE: after position 0.
  - DONE → IDLE: 1 cycle.
- **DONE outputs**
  - `numeric` = parse ok AND `seen_digit`.
  - `value` = `neg ? -acc : acc`, sign-extended to 32 bits; forced to 0 when not numeric.
  - `blank` = every glyph is 0x00.
  - `image` = work register.
  - `frame_valid` = 1 for one cycle.
- **Special frames**
  - All-minus (0x40 ×6): numeric=0, blank=0.
  - Minus followed by only blanks: numeric=0.

## Timing
- **Reset values:** `value`=0, `numeric`=0, `blank`=0, `image`=0, `frame_valid`=0, `busy`=0.
  - Reset also sets `seen`=0, counter=0, published flag=0 and the FSM to IDLE.
- **Latency**, with the sixth distinct position captured at edge E:
  - Candidate compare and counter update: E+1.
  - Accept: E+1. `busy` is high from E+1.
  - DECODE: edges E+2…E+7.
  - DONE: E+8. `frame_valid` and the outputs update at E+8.
  - `busy` falls at E+9.
- Outputs hold between pulses; `frame_valid` is never high for two consecutive cycles.
- Capture and stability counting keep running during DECODE/DONE.
- Reset mid-decode returns every output to its reset value immediately, with no pulse.

## Test plan
- **Numeric frame.** Stimulus: scan "123456" (pos5..0 = 0x06,0x5B,0x4F,0x66,0x6D,0x7D) for two frames, cycling positions 0→5. Required response: one `frame_valid`, `value`=0x0001E240, `numeric`=1, `blank`=0.
- **Negative frame.** Stimulus: scan "-   12" (0x40,0,0,0,0x06,0x5B), stable. Required response: `value`=0xFFFFFFF4, `numeric`=1.
- **Non-numeric frames.**
  - Reset pattern "------": `numeric`=0, `value`=0.
  - " Error" (0,0x79,0x50,0x50,0x5C,0x50): `numeric`=0, `image`=48'h0079_5050_5C50.
- **Blank and repeat.** Stimulus: all-blank frame after reset. Required response: pulse with `blank`=1, `numeric`=0. Stimulus: the same frame repeated for 10 frames. Required response: no further pulse.
- **Instability and illegal select.**
  - Alternate "000001"/"000002" every frame with `STABLE_FRAMES`=2: no pulse.
  - Inject `fnd_s`=6'b111100 mid-frame: that frame is discarded, so acceptance slips by one frame.
- **Reset mid-decode.** Stimulus: assert `rst` at E+4 of a decode. Required response: all outputs 0, `busy`=0, no pulse. After release, two stable frames give a normal pulse at the specified latency.
